// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file of the 16-bit core.
// Selects the MEM/WB result, commits it to an 8-entry register file and
// serves two combinational read ports with same-cycle write-through bypass.
module wb_register_file #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [DATA_W-1:0] Controll_Signal_In,
  input  logic [DATA_W-1:0] Add_Result_In,
  input  logic [DATA_W-1:0] Mem_Result_In,
  input  logic [DATA_W-1:0] Alu_Result_In,
  input  logic [DATA_W-1:0] Rd_In,
  input  logic [ADDR_W-1:0] Read_Addr_1,
  input  logic [ADDR_W-1:0] Read_Addr_2,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  output logic [DATA_W-1:0] Wb_Data_Out,
  output logic [ADDR_W-1:0] Wb_Rd_Out,
  output logic              Wb_Enable_Out,
  output logic [DATA_W-1:0] Write_Count_Out
);

  // Architectural state; zero at power-up so simulation starts defined.
  logic [DATA_W-1:0] regs_q [REG_COUNT] = '{default: '0};
  logic [DATA_W-1:0] cnt_q = '0;
  logic [DATA_W-1:0] cnt_d;

  logic              reg_write_s;
  logic [1:0]        wb_sel_s;
  logic [ADDR_W-1:0] wb_rd_s;
  logic [DATA_W-1:0] wb_data_s;
  logic              wb_en_s;

  // Upper control and destination bits are don't-care by design.
  logic unused_bits_s;
  assign unused_bits_s = ^{Controll_Signal_In[DATA_W-1:3], Rd_In[DATA_W-1:ADDR_W]};

  assign reg_write_s = Controll_Signal_In[0];
  assign wb_sel_s    = Controll_Signal_In[2:1];
  assign wb_rd_s     = Rd_In[ADDR_W-1:0];

  // Resolve one read port: R0 reads zero, a pending write is bypassed,
  // otherwise the stored value is returned.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (addr == {ADDR_W{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else if (en && (addr == wr_addr)) begin
      val = wr_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write-back source select; the reserved encoding yields zero.
  always_comb begin
    wb_data_s = {DATA_W{1'b0}};
    case (wb_sel_s)
      2'b00:   wb_data_s = Alu_Result_In;
      2'b01:   wb_data_s = Mem_Result_In;
      2'b10:   wb_data_s = Add_Result_In;
      2'b11:   wb_data_s = {DATA_W{1'b0}};
      default: wb_data_s = {DATA_W{1'b0}};
    endcase
  end

  // A write commits only outside reset, with a valid source and a non-zero target.
  always_comb begin
    wb_en_s = 1'b0;
    if (!rest && reg_write_s && (wb_sel_s != 2'b11) && (wb_rd_s != {ADDR_W{1'b0}})) begin
      wb_en_s = 1'b1;
    end else begin
      wb_en_s = 1'b0;
    end
  end

  // Retired-write counter next state; wraps silently.
  always_comb begin
    cnt_d = cnt_q;
    if (wb_en_s) begin
      cnt_d = cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Both read ports resolved independently against the same write.
  always_comb begin
    Read_Data_1 = {DATA_W{1'b0}};
    Read_Data_2 = {DATA_W{1'b0}};
    Read_Data_1 = read_port(Read_Addr_1, wb_en_s, wb_rd_s, wb_data_s, regs_q[Read_Addr_1]);
    Read_Data_2 = read_port(Read_Addr_2, wb_en_s, wb_rd_s, wb_data_s, regs_q[Read_Addr_2]);
  end

  assign Wb_Data_Out     = wb_data_s;
  assign Wb_Rd_Out       = wb_rd_s;
  assign Wb_Enable_Out   = wb_en_s;
  assign Write_Count_Out = cnt_q;

  // Register array and counter update; reset clears everything and drops any write.
  always_ff @(posedge clk) begin
    if (rest) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      cnt_q <= {DATA_W{1'b0}};
    end else begin
      if (wb_en_s) begin
        regs_q[wb_rd_s] <= wb_data_s;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed scenarios plus random
// traffic compared against a behavioural register-file model.
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        rest;
  logic [15:0] ctrl, add_v, mem_v, alu_v, rd_v;
  logic [2:0]  ra1, ra2;
  logic [15:0] rdata1, rdata2, wb_data, wcount;
  logic [2:0]  wb_rd;
  logic        wb_en;

  logic [15:0] model_regs [8];
  logic [15:0] model_cnt;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_register_file dut (
    .clk(clk), .rest(rest),
    .Controll_Signal_In(ctrl), .Add_Result_In(add_v), .Mem_Result_In(mem_v),
    .Alu_Result_In(alu_v), .Rd_In(rd_v),
    .Read_Addr_1(ra1), .Read_Addr_2(ra2),
    .Read_Data_1(rdata1), .Read_Data_2(rdata2),
    .Wb_Data_Out(wb_data), .Wb_Rd_Out(wb_rd), .Wb_Enable_Out(wb_en),
    .Write_Count_Out(wcount)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: value chosen by the write-back select field.
  function automatic logic [15:0] m_data();
    int sel;
    sel = (int'(ctrl) / 2) % 4;
    if (sel == 0) return alu_v;
    if (sel == 1) return mem_v;
    if (sel == 2) return add_v;
    return 16'h0000;
  endfunction

  function automatic logic m_en();
    int sel;
    sel = (int'(ctrl) / 2) % 4;
    return (rest == 1'b0) && (int'(ctrl) % 2 == 1) && (sel != 3) && (int'(rd_v) % 8 != 0);
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (m_en() && (int'(a) == int'(rd_v) % 8)) return m_data();
    return model_regs[a];
  endfunction

  task automatic m_edge();
    logic        en;
    logic [15:0] d;
    en = m_en();
    d  = m_data();
    @(posedge clk);
    if (rest) begin
      for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
      model_cnt = 16'h0000;
    end else if (en) begin
      model_regs[int'(rd_v) % 8] = d;
      model_cnt = model_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic [15:0] c, input logic [15:0] a,
                       input logic [15:0] m, input logic [15:0] al, input logic [15:0] d,
                       input logic [2:0] x1, input logic [2:0] x2);
    rest = r; ctrl = c; add_v = a; mem_v = m; alu_v = al; rd_v = d; ra1 = x1; ra2 = x2;
  endtask

  // Apply one cycle, check all combinational outputs and the counter, then clock it.
  task automatic apply(input logic r, input logic [15:0] c, input logic [15:0] a,
                       input logic [15:0] m, input logic [15:0] al, input logic [15:0] d,
                       input logic [2:0] x1, input logic [2:0] x2);
    drive(r, c, a, m, al, d, x1, x2);
    #2;
    chk("wb_data", wb_data, m_data());
    chk("wb_en", {15'd0, wb_en}, {15'd0, m_en()});
    chk("wb_rd", {13'd0, wb_rd}, 16'(int'(rd_v) % 8));
    chk("read1", rdata1, m_read(ra1));
    chk("read2", rdata2, m_read(ra2));
    chk("count", wcount, model_cnt);
    m_edge();
  endtask

  task automatic peek(input logic [2:0] x1, input logic [2:0] x2);
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, x1, x2);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    model_cnt = 16'h0000;

    // Reset, preload R3, then reset with a write pending.
    apply(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0);
    apply(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h1234, 16'h0003, 3'd3, 3'd0);
    apply(1'b1, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0003, 3'd3, 3'd3);
    peek(3'd3, 3'd0);
    chk("rst_r3", rdata1, 16'h0000);
    chk("rst_cnt", wcount, 16'h0000);

    // Write-back mux into R5.
    apply(1'b0, 16'h0001, 16'h3333, 16'h2222, 16'h1111, 16'h0005, 3'd5, 3'd0);
    peek(3'd5, 3'd0);
    chk("mux_alu", rdata1, 16'h1111);
    apply(1'b0, 16'h0003, 16'h3333, 16'h2222, 16'h1111, 16'h0005, 3'd5, 3'd0);
    peek(3'd5, 3'd0);
    chk("mux_mem", rdata1, 16'h2222);
    apply(1'b0, 16'h0005, 16'h3333, 16'h2222, 16'h1111, 16'h0005, 3'd5, 3'd0);
    peek(3'd5, 3'd0);
    chk("mux_add", rdata1, 16'h3333);
    apply(1'b0, 16'h0007, 16'h3333, 16'h2222, 16'h1111, 16'h0005, 3'd5, 3'd0);
    peek(3'd5, 3'd0);
    chk("mux_rsv_r5", rdata1, 16'h3333);
    chk("mux_rsv_cnt", wcount, 16'h0003);

    // Write-through bypass on both ports.
    apply(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h00AA, 16'h0002, 3'd2, 3'd0);
    drive(1'b0, 16'h0003, 16'h0000, 16'hBEEF, 16'h0000, 16'h0002, 3'd2, 3'd2);
    #1;
    chk("byp_p1", rdata1, 16'hBEEF);
    chk("byp_p2", rdata2, 16'hBEEF);
    apply(1'b0, 16'h0003, 16'h0000, 16'hBEEF, 16'h0000, 16'h0002, 3'd2, 3'd2);
    peek(3'd2, 3'd2);
    chk("byp_array", rdata2, 16'hBEEF);

    // R0 is never written, including via aliased Rd_In=0x0008.
    apply(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h5555, 16'h0000, 3'd0, 3'd0);
    apply(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h5555, 16'h0008, 3'd0, 3'd0);
    peek(3'd0, 3'd0);
    chk("r0_read", rdata1, 16'h0000);
    chk("r0_cnt", wcount, 16'h0005);

    // Held MEM/WB: same write on three edges.
    for (int k = 0; k < 3; k++)
      apply(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0C0C, 16'h0004, 3'd4, 3'd4);
    peek(3'd4, 3'd0);
    chk("held_r4", rdata1, 16'h0C0C);
    chk("held_cnt", wcount, 16'h0008);

    // Random traffic, with occasional reset and junk upper bits.
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom));
    end

    // Counter wrap: 0xFFFE commits after reset, then two more.
    apply(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0);
    for (int k = 0; k < 16'hFFFE; k++) begin
      drive(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'($urandom),
            16'($urandom_range(1, 7)), 3'd1, 3'd2);
      m_edge();
    end
    apply(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h7777, 16'h0006, 3'd6, 3'd1);
    peek(3'd6, 3'd0);
    chk("wrap_ffff", wcount, 16'hFFFF);
    apply(1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h8888, 16'h0007, 3'd7, 3'd6);
    peek(3'd7, 3'd0);
    chk("wrap_0000", wcount, 16'h0000);
    chk("wrap_r7", rdata1, 16'h8888);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
